// File: rtl/level_stream_arbiter.sv
// Window-atomic round-robin arbiter: forwards whole BEATS-beat windows from one pyramid level
// at a time onto the shared stream bus. Define ARB_HEADER_EN to prepend a sequence-numbered header beat.
module level_stream_arbiter #(
   parameter int BUS_WIDTH = 128,
   parameter int LEVELS    = 7,
   parameter int BEATS     = 10,
   parameter int LVL_W     = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [LEVELS-1:0]           in_valid,
   input  logic [BUS_WIDTH*LEVELS-1:0] in_stream,
   output logic [LEVELS-1:0]           in_ready,
   output logic [BUS_WIDTH-1:0]        out_stream,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic [LVL_W-1:0]            out_level,
   output logic                        busy
);

   localparam int NSLOT = 1 << LVL_W;
   localparam int CNT_W = $clog2(BEATS + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
`ifdef ARB_HEADER_EN
   localparam logic [1:0] ST_HDR  = 2'd2;
`endif

   logic [1:0]           state;
   logic [LVL_W-1:0]     grant;
   logic [LVL_W-1:0]     last_grant;
   logic [LVL_W-1:0]     pick;
   logic [CNT_W-1:0]     beat_cnt;
   logic [BUS_WIDTH-1:0] lane [NSLOT];
   logic [NSLOT-1:0]     vld_pad;
   logic                 out_space;
   logic                 in_fire;
   logic                 last_beat;

   logic [BUS_WIDTH-1:0] data_p1;
   logic                 vld_p1;
   logic                 last_p1;
   logic [LVL_W-1:0]     level_p1;

   // First requesting level strictly after 'last', wrapping within LEVELS.
   function automatic logic [LVL_W-1:0] rr_pick(input logic [LEVELS-1:0] req,
                                                input logic [LVL_W-1:0]  last);
      logic [LVL_W-1:0] sel;
      logic             found;
      int               idx;
      sel   = '0;
      found = 1'b0;
      for (int k = 1; k <= LEVELS; k++) begin
         idx = (int'(last) + k) % LEVELS;
         if (!found && ((req >> idx) & LEVELS'(1)) != '0) begin
            sel   = LVL_W'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   // Lanes padded to a power of two so a grant index can never select outside the array.
   genvar j;
   generate
      for (j = 0; j < NSLOT; j++) begin : g_lane
         if (j < LEVELS) begin : g_real
            assign lane[j] = in_stream[j*BUS_WIDTH +: BUS_WIDTH];
         end else begin : g_pad
            assign lane[j] = '0;
         end
      end
   endgenerate

   assign vld_pad   = NSLOT'(in_valid);
   assign out_space = !vld_p1 || out_ready;
   assign in_fire   = (state == ST_XFER) && out_space && vld_pad[grant];
   assign in_ready  = (state == ST_XFER && out_space) ? LEVELS'(NSLOT'(1) << grant) : '0;
   assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
   assign pick      = rr_pick(in_valid, last_grant);
   assign busy      = (state != ST_IDLE);

`ifdef ARB_HEADER_EN
   logic [15:0]          seq_cnt;
   logic                 hdr_fire;
   logic [BUS_WIDTH-1:0] hdr_beat;

   assign hdr_fire = (state == ST_HDR) && out_space;
   assign hdr_beat = {16'hA5C3, seq_cnt, grant, {(BUS_WIDTH - 32 - LVL_W){1'b0}}};
`endif

   // stage p0: packet control (arbitration, beat counting)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= LVL_W'(LEVELS - 1);
         beat_cnt   <= '0;
`ifdef ARB_HEADER_EN
         seq_cnt    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (|in_valid) begin
                  grant      <= pick;
                  last_grant <= pick;
                  beat_cnt   <= '0;
`ifdef ARB_HEADER_EN
                  state      <= ST_HDR;
`else
                  state      <= ST_XFER;
`endif
               end
            end
`ifdef ARB_HEADER_EN
            ST_HDR: begin
               if (out_space) begin
                  state   <= ST_XFER;
                  seq_cnt <= seq_cnt + 16'd1;
               end
            end
`endif
            ST_XFER: begin
               if (in_fire) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (last_beat) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // stage p1: registered output beat, held while the sink stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         data_p1  <= '0;
         last_p1  <= 1'b0;
         level_p1 <= '0;
      end else if (in_fire) begin
         vld_p1   <= 1'b1;
         data_p1  <= lane[grant];
         last_p1  <= last_beat;
         level_p1 <= grant;
      end
`ifdef ARB_HEADER_EN
      else if (hdr_fire) begin
         vld_p1   <= 1'b1;
         data_p1  <= hdr_beat;
         last_p1  <= 1'b0;
         level_p1 <= grant;
      end
`endif
      else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid  = vld_p1;
   assign out_stream = data_p1;
   assign out_last   = last_p1;
   assign out_level  = level_p1;

endmodule

// File: tb/tb_level_stream_arbiter.sv
// Directed bench for level_stream_arbiter: packet-level round-robin model plus literal spot checks.
module tb_level_stream_arbiter;

   localparam int BUS_WIDTH = 128;
   localparam int LEVELS    = 7;
   localparam int BEATS     = 10;
   localparam int LVL_W     = 3;
`ifdef ARB_HEADER_EN
   localparam int PKT_LEN = BEATS + 1;
`else
   localparam int PKT_LEN = BEATS;
`endif

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b1;
   logic [LEVELS-1:0]           in_valid;
   logic [BUS_WIDTH*LEVELS-1:0] in_stream;
   logic [LEVELS-1:0]           in_ready;
   logic [BUS_WIDTH-1:0]        out_stream;
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_last;
   logic [LVL_W-1:0]            out_level;
   logic                        busy;

   always #5 clk = ~clk;

   level_stream_arbiter #(
      .BUS_WIDTH(BUS_WIDTH), .LEVELS(LEVELS), .BEATS(BEATS), .LVL_W(LVL_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_stream(in_stream),
      .in_ready(in_ready), .out_stream(out_stream), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .out_level(out_level), .busy(busy)
   );

   typedef struct {
      logic [BUS_WIDTH-1:0] data;
      logic [LVL_W-1:0]     lvl;
      logic                 last;
      logic                 first;
   } beat_t;

   int n_run = 0;
   int n_fail = 0;

   // sources
   int rem [LEVELS];
   int sent [LEVELS];
   int plan [LEVELS];
   int test_id = 0;
   int cyc = 0;
   int bp_on = 0;
   int bub_lvl = 1, bub_at = 0, bub_len = 0, bub_left = 0, bub_armed = 0;
   int guard_lvl = -1;
   int out_beats = 0, out_lasts = 0;

   // model
   beat_t exp_q [$];
   int    pkt_log [$];
   int    m_tid = 0;
   int    m_pend [LEVELS];
   int    m_sent [LEVELS];
   int    m_last = LEVELS - 1;
   int    m_seq = 0;
   logic                 prev_hold = 1'b0;
   logic [BUS_WIDTH-1:0] p_data;
   logic                 p_last;
   logic [LVL_W-1:0]     p_level;

   function automatic logic [BUS_WIDTH-1:0] beat_val(input int lvl, input int n);
      return {96'h0, 8'(lvl), 8'h00, 16'(n + 1)};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int log_at(input int i);
      return (i < pkt_log.size()) ? pkt_log[i] : -1;
   endfunction

   // Next window in round-robin order over the levels that still have windows to send.
   task automatic gen_packet();
      beat_t b;
      int    g;
      g = -1;
      for (int k = 1; k <= LEVELS; k++) begin
         if (g < 0 && m_pend[(m_last + k) % LEVELS] > 0) g = (m_last + k) % LEVELS;
      end
      if (g < 0) return;
      m_last = g;
      m_pend[g]--;
`ifdef ARB_HEADER_EN
      b.data  = {16'hA5C3, 16'(m_seq), LVL_W'(g), {(BUS_WIDTH - 32 - LVL_W){1'b0}}};
      b.lvl   = LVL_W'(g);
      b.last  = 1'b0;
      b.first = 1'b1;
      exp_q.push_back(b);
      m_seq++;
`endif
      for (int k = 0; k < BEATS; k++) begin
         b.data  = beat_val(g, m_sent[g] + k);
         b.lvl   = LVL_W'(g);
         b.last  = (k == BEATS - 1);
         b.first = (k == 0) && (PKT_LEN == BEATS);
         exp_q.push_back(b);
      end
      m_sent[g] += BEATS;
   endtask

   task automatic compare_cycle();
      beat_t e;
      if (test_id != m_tid) begin
         m_tid = test_id;
         for (int j = 0; j < LEVELS; j++) begin
            m_pend[j] = plan[j];
            m_sent[j] = 0;
         end
      end
      if (!rst_n) begin
         check("reset out_valid", out_valid, 0);
         check("reset in_ready", in_ready, 0);
         check("reset busy", busy, 0);
         exp_q.delete();
         m_last = LEVELS - 1;
         m_seq = 0;
         prev_hold = 1'b0;
         return;
      end
      if (prev_hold) begin
         check("hold out_valid", out_valid, 1);
         check("hold out_stream", out_stream, p_data);
         check("hold out_last", out_last, p_last);
         check("hold out_level", out_level, p_level);
      end
      if (out_valid && !out_ready) check("stall in_ready", in_ready, 0);
      check("in_ready onehot0", $onehot0(in_ready), 1);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) gen_packet();
         if (exp_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected beat: got %h level %0d expected no beat", out_stream, out_level);
         end else begin
            e = exp_q.pop_front();
            check("out_stream", out_stream, e.data);
            check("out_level", out_level, e.lvl);
            check("out_last", out_last, e.last);
            if (e.first) pkt_log.push_back(int'(out_level));
         end
      end
      prev_hold = out_valid && !out_ready;
      p_data    = out_stream;
      p_last    = out_last;
      p_level   = out_level;
   endtask

   task automatic drive();
      for (int j = 0; j < LEVELS; j++) begin
         in_valid[j] = (rem[j] > 0) && !(j == bub_lvl && bub_left > 0);
         in_stream[j*BUS_WIDTH +: BUS_WIDTH] = beat_val(j, sent[j]);
      end
   endtask

   task automatic cycle();
      logic [LEVELS-1:0] fires;
      @(negedge clk);
      compare_cycle();
      fires = in_valid & in_ready;
      if (rst_n && out_valid && out_ready) begin
         out_beats++;
         if (out_last) out_lasts++;
      end
      if (guard_lvl >= 0 && sent[bub_lvl] < BEATS) check("held-off in_ready", in_ready[guard_lvl], 0);
      @(posedge clk);
      #1;
      cyc++;
      for (int j = 0; j < LEVELS; j++) begin
         if (fires[j]) begin
            sent[j]++;
            rem[j]--;
         end
      end
      if (bub_left > 0) bub_left--;
      if (bub_armed != 0 && fires[bub_lvl] && sent[bub_lvl] == bub_at) begin
         bub_left  = bub_len;
         bub_armed = 0;
      end
      out_ready = (bp_on != 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      drive();
   endtask

   task automatic clear_plan();
      for (int j = 0; j < LEVELS; j++) plan[j] = 0;
   endtask

   task automatic go();
      test_id++;
      for (int j = 0; j < LEVELS; j++) begin
         rem[j]  = plan[j] * BEATS;
         sent[j] = 0;
      end
      out_beats = 0;
      out_lasts = 0;
      drive();
   endtask

   function automatic int all_sent();
      int s;
      s = 0;
      for (int j = 0; j < LEVELS; j++) s += rem[j];
      return s;
   endfunction

   task automatic wait_done(input string name, input int budget);
      int n;
      int pend;
      n = 0;
      while (!(all_sent() == 0 && !out_valid && !busy) && n < budget) begin
         cycle();
         n++;
      end
      n_run++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL %s timeout: got %0d beats still pending, required 0", name, all_sent());
      end
      cycle();
      pend = 0;
      for (int j = 0; j < LEVELS; j++) pend += m_pend[j];
      check({name, " model drained"}, exp_q.size(), 0);
      check({name, " windows emitted"}, pend, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_plan();
      go();
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      int base;
      int seen9, seen10;
      in_valid  = '0;
      in_stream = '0;
      out_ready = 1'b1;
      for (int j = 0; j < LEVELS; j++) begin
         rem[j] = 0; sent[j] = 0; plan[j] = 0; m_pend[j] = 0; m_sent[j] = 0;
      end
      #1 rst_n = 1'b0;
      cycle();
      cycle();
      check("reset out_stream", out_stream, 0);
      check("reset out_level", out_level, 0);
      check("reset out_last", out_last, 0);
      rst_n = 1'b1;
      cycle();

      // single level 3
      clear_plan();
      plan[3] = 1;
      go();
      seen9 = 0;
      seen10 = 0;
      for (int n = 0; n < 60 && seen10 == 0; n++) begin
         cycle();
         if (sent[3] == 9 && seen9 == 0) begin
            seen9 = 1;
            check("single busy mid", busy, 1);
            check("single last early", out_last, 0);
         end
         if (sent[3] == 10) begin
            seen10 = 1;
            check("single busy falls", busy, 0);
            check("single last beat", out_stream, 128'h0300000A);
            check("single out_last", out_last, 1);
            check("single out_level", out_level, 3);
         end
      end
      check("single reached beat 10", seen10, 1);
      wait_done("single", 60);
      check("single beat count", out_beats, PKT_LEN);

      // contention 0,2,6
      do_reset();
      base = pkt_log.size();
      clear_plan();
      plan[0] = 2; plan[2] = 2; plan[6] = 2;
      go();
      wait_done("contention", 300);
      check("contention pkt0", log_at(base + 0), 0);
      check("contention pkt1", log_at(base + 1), 2);
      check("contention pkt2", log_at(base + 2), 6);
      check("contention pkt3", log_at(base + 3), 0);
      check("contention pkt4", log_at(base + 4), 2);
      check("contention pkt5", log_at(base + 5), 6);
      check("contention lasts", out_lasts, 6);

      // backpressure 1,0,0,1
      base = pkt_log.size();
      bp_on = 1;
      clear_plan();
      plan[4] = 1; plan[5] = 1;
      go();
      wait_done("backpressure", 400);
      bp_on = 0;
      check("bp pkt0", log_at(base + 0), 4);
      check("bp pkt1", log_at(base + 1), 5);
      check("bp beat count", out_beats, 2 * PKT_LEN);

      // upstream bubble on level 1 while level 5 waits
      base = pkt_log.size();
      bub_lvl = 1; bub_at = 4; bub_len = 5; bub_armed = 1;
      guard_lvl = 5;
      clear_plan();
      plan[1] = 1; plan[5] = 1;
      go();
      wait_done("bubble", 200);
      guard_lvl = -1;
      check("bubble pkt0", log_at(base + 0), 1);
      check("bubble pkt1", log_at(base + 1), 5);

      // async reset mid-packet
      clear_plan();
      plan[3] = 1;
      go();
      for (int n = 0; n < 40 && sent[3] < 6; n++) cycle();
      check("pre-reset out_valid", out_valid, 1);
      check("pre-reset busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async out_valid", out_valid, 0);
      check("async in_ready", in_ready, 0);
      check("async busy", busy, 0);
      check("async out_stream", out_stream, 0);
      clear_plan();
      plan[0] = 1; plan[4] = 1;
      go();
      cycle();
      cycle();
      base = pkt_log.size();
      rst_n = 1'b1;
      wait_done("post-reset", 200);
      check("post-reset pkt0", log_at(base + 0), 0);
      check("post-reset pkt1", log_at(base + 1), 4);

      // two windows from level 2
      do_reset();
      clear_plan();
      plan[2] = 2;
      go();
`ifdef ARB_HEADER_EN
      for (int n = 0; n < 10 && !out_valid; n++) cycle();
      check("header beat", out_stream, 128'hA5C3_0000_4000_0000_0000_0000_0000_0000);
      check("header level", out_level, 2);
      check("header last", out_last, 0);
`endif
      wait_done("level2", 200);
      check("level2 beat count", out_beats, 2 * PKT_LEN);
      check("level2 lasts", out_lasts, 2);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: simulation still running, required finish");
      $fatal(1);
   end

endmodule
